// File: rtl/can_crc_checker.sv
// Receive-side CAN CRC-15 checker: runs the CRC over SOF..end of data, captures the
// received CRC field, samples the delimiter and reports a registered per-frame verdict.
module can_crc_checker #(
    parameter logic [14:0] SEED     = 15'h0000,
    parameter int          MAX_BITS = 103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_i,
    input  logic        din_valid_i,
    input  logic        sof_i,
    input  logic        crc_start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic [14:0] calc_crc_o,
    output logic [14:0] rx_crc_o,
    output logic        done_o,
    output logic        crc_ok_o,
    output logic        crc_err_o,
    output logic        delim_err_o,
    output logic        len_err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DELIM   = 2'd3
    } state_t;

    localparam logic [14:0] POLY    = 15'h4599;
    localparam logic [6:0]  MAX_CNT = 7'(MAX_BITS);

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        logic nxt;
        nxt      = b ^ crc[14];
        crc_step = {crc[13:0], 1'b0} ^ (nxt ? POLY : 15'h0000);
    endfunction

    state_t      state_q, state_d;
    logic [14:0] crc_q, crc_d;
    logic [14:0] rx_q, rx_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  cap_cnt_q, cap_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        crc_err_q, crc_err_d;
    logic        delim_err_q, delim_err_d;
    logic        len_err_q, len_err_d;

    // Next-state and verdict logic; abort beats sof, sof restarts from any state.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        crc_err_d   = crc_err_q;
        delim_err_d = delim_err_q;
        len_err_d   = len_err_q;

        if (abort_i) begin
            state_d     = S_IDLE;
            ok_d        = 1'b0;
            crc_err_d   = 1'b0;
            delim_err_d = 1'b0;
            len_err_d   = 1'b0;
        end else if (din_valid_i && sof_i) begin
            state_d     = S_CALC;
            crc_d       = crc_step(SEED, din_i);
            bit_cnt_d   = 7'd1;
            ok_d        = 1'b0;
            crc_err_d   = 1'b0;
            delim_err_d = 1'b0;
            len_err_d   = 1'b0;
        end else if (din_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_CALC: begin
                    if (crc_start_i) begin
                        rx_d      = {14'b0, din_i};
                        cap_cnt_d = 4'd1;
                        state_d   = S_CAPTURE;
                    end else if (bit_cnt_q >= MAX_CNT) begin
                        len_err_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        crc_d     = crc_step(crc_q, din_i);
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                S_CAPTURE: begin
                    rx_d      = {rx_q[13:0], din_i};
                    cap_cnt_d = cap_cnt_q + 4'd1;
                    if (cap_cnt_q == 4'd14) begin
                        state_d = S_DELIM;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
                S_DELIM: begin
                    delim_err_d = ~din_i;
                    crc_err_d   = (crc_q != rx_q);
                    ok_d        = (crc_q == rx_q) & din_i;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            crc_q       <= SEED;
            rx_q        <= 15'h0000;
            bit_cnt_q   <= 7'd0;
            cap_cnt_q   <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            crc_err_q   <= 1'b0;
            delim_err_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            crc_err_q   <= crc_err_d;
            delim_err_q <= delim_err_d;
            len_err_q   <= len_err_d;
        end
    end

    assign busy_o      = busy_q;
    assign calc_crc_o  = crc_q;
    assign rx_crc_o    = rx_q;
    assign done_o      = done_q;
    assign crc_ok_o    = ok_q;
    assign crc_err_o   = crc_err_q;
    assign delim_err_o = delim_err_q;
    assign len_err_o   = len_err_q;

endmodule

// File: doc/can_crc_checker.md
# can_crc_checker

Receive-side CRC-15 checker for the CAN 2.0 controller. It consumes the de-stuffed receive bitstream from SOF through the end of the data field and runs the CAN CRC-15 LFSR (polynomial 0x4599) over it. It then captures the 15 received CRC bits and checks the CRC delimiter. It sits between the bit de-stuffer and the receive frame FSM, and reports a per-frame pass/fail verdict that drives ACK/error signalling.

## Interface
- SEED, 15'h0000, LFSR seed loaded at SOF; must equal the transmitter's seed.
- MAX_BITS, 103, maximum bits from SOF to end of data field (extended frame, 8 data bytes).
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  de-stuffed receive bit.
- din_valid  in  1  one-cycle strobe; din is consumed only when high.
- sof  in  1  qualified by din_valid; marks the SOF bit (included in CRC).
- crc_start  in  1  qualified by din_valid; marks the first (MSB) received CRC bit.
- abort  in  1  error frame / bus-off; forces IDLE immediately.
- busy  out  1  high in CALC, CAPTURE, DELIM.
- calc_crc  out  15  computed CRC, frozen at crc_start.
- rx_crc  out  15  received CRC field.
- done  out  1  one-cycle pulse when a verdict is available.
- crc_ok  out  1  verdict: calc_crc == rx_crc and delimiter recessive.
- crc_err  out  1  verdict: CRC mismatch.
- delim_err  out  1  verdict: CRC delimiter sampled dominant (0).
- len_err  out  1  verdict: MAX_BITS exceeded without crc_start.

## Operation
- States: IDLE, CALC, CAPTURE, DELIM.
- LFSR step on each consumed CALC bit:
  - nxt = din ^ crc[14]
  - crc = {crc[13:0],1'b0}
  - if nxt, crc ^= 15'h4599
- IDLE:
  - sof & din_valid: crc = SEED, step with din, bit_cnt = 1, clear all verdict flags, go to CALC.
  - crc_start and other bits are ignored.
- CALC:
  - Each valid bit without crc_start: step the LFSR, bit_cnt++.
  - If bit_cnt reaches MAX_BITS and the next valid bit is not crc_start: len_err=1, done pulse, go to IDLE.
  - crc_start & din_valid: freeze calc_crc (that bit is not stepped), rx_crc = {14'b0,din}, cap_cnt = 1, go to CAPTURE.
- CAPTURE:
  - Each valid bit shifts in: rx_crc = {rx_crc[13:0],din} (MSB first).
  - After the 15th bit, go to DELIM.
  - crc_start is ignored here.
- DELIM:
  - Next valid bit is the delimiter.
  - delim_err = ~din; crc_err = (calc_crc != rx_crc); crc_ok = ~crc_err & ~delim_err.
  - done pulse, go to IDLE.
- Verdict flags hold until the next accepted sof or reset.
- sof & din_valid while busy: restart the frame as from IDLE; no done for the abandoned frame.
- abort: go to IDLE the next cycle with no done and flags cleared. abort wins over a simultaneous sof or din_valid.
- din_valid low: all state holds.

## Timing
- Reset values: state IDLE; busy 0; calc_crc SEED; rx_crc 0; done 0; crc_ok 0; crc_err 0; delim_err 0; len_err 0.
- Registered outputs; busy rises the cycle after the sof strobe.
- done and flags assert in the same cycle, one clock after the delimiter strobe.
- Back-to-back valid strobes (every cycle) are supported, with no bubbles required.
- Counters: bit_cnt is 7 bits and saturates at MAX_BITS; cap_cnt is 4 bits.
- Reset mid-frame returns to IDLE asynchronously with reset values.

## Test plan
- Bits 0,1 (sof on the first) → calc_crc 15'h4599. Send rx CRC 0x4599 MSB first, then delimiter 1 → done, crc_ok=1, other flags 0.
- Bits 0,1,0 → calc_crc 15'h4EAB. Send rx CRC 0x4EAA, delimiter 1 → crc_err=1, crc_ok=0.
- 83 zero bits, rx CRC 0x0000, delimiter 0 → delim_err=1, crc_err=0, crc_ok=0.
- 104 valid bits without crc_start → len_err=1 with done on the 104th bit; busy drops.
- Assert abort mid-CAPTURE → no done, flags 0, IDLE. Then a new sof frame (bits 0,1, CRC 0x4599) → crc_ok=1.
- Gapped din_valid (random idle cycles) on the first scenario → identical result. Also assert rst_n low mid-CALC → all outputs return to reset values immediately.
